// File: rtl/io_bridge_if.sv
// io_bridge_if: CPU data-memory port as seen by the memory-mapped I/O bridge.
interface io_bridge_if;
   logic        write;
   logic [9:0]  address;
   logic [31:0] writedata;
   logic        io_sel;
   logic [31:0] io_readdata;
   modport master (output write, address, writedata, input io_sel, io_readdata);
   modport slave  (input write, address, writedata, output io_sel, io_readdata);
endinterface

// File: rtl/io_bridge.sv
// io_bridge: memory-mapped LED/HEX/SW/KEY/cycle-counter slave with debounced inputs.
module io_bridge #(
   parameter logic [1:0] IO_BASE      = 2'b11,
   parameter int         DEBOUNCE_CYC = 500000
) (
   input  logic          clk,
   input  logic          rst_n,
   io_bridge_if.slave    bus,
   input  logic [9:0]    sw_in,
   input  logic [2:0]    key_in,
   output logic [9:0]    ledr,
   output logic [6:0]    hex0,
   output logic [6:0]    hex1,
   output logic [6:0]    hex2,
   output logic [6:0]    hex3,
   output logic [6:0]    hex4,
   output logic [6:0]    hex5
);
   localparam int CW = $clog2(DEBOUNCE_CYC);
   localparam int N  = 13;
   // SW in bits [9:0], raw active-low KEY in [12:10]; keys idle high
   localparam logic [N-1:0] IN_RST = {3'b111, 10'b0};
   localparam logic [15:0][6:0] SEG = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                       7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
   logic [23:0]          hexdat;
   logic [5:0]           blank;
   logic [2:0]           keyev, clr, press;
   logic [31:0]          cycles, rd;
   logic [N-1:0]         s1, s2, deb, deb_nxt;
   logic [N-1:0][CW-1:0] cnt, cnt_nxt;
   logic [5:0][6:0]      hex_r;
   logic [2:0]           off;
   logic                 wr, unused;
   assign bus.io_sel = bus.address[9:8] == IO_BASE;
   assign off = bus.address[2:0];
   assign wr = bus.write & bus.io_sel;
   assign {hex5, hex4, hex3, hex2, hex1, hex0} = hex_r;
   assign unused = ^{bus.writedata[31:24], bus.address[7:3]};
   always_comb begin
      deb_nxt = deb;
      cnt_nxt = cnt;
      for (int i = 0; i < N; i++) begin
         deb_nxt[i] = (s2[i] != deb[i] && cnt[i] == CW'(DEBOUNCE_CYC - 1)) ? s2[i] : deb[i];
         cnt_nxt[i] = (s2[i] == deb[i] || deb_nxt[i] != deb[i]) ? '0 : cnt[i] + 1'b1;
      end
   end
   // raw key falling to 0 in the debounced domain is a press
   assign press = deb[12:10] & ~deb_nxt[12:10];
   assign clr = (wr && off == 3'd5) ? bus.writedata[2:0] : 3'b0;
   always_comb begin
      rd = '0;
      case (off)
         3'd0: rd = {22'b0, ledr};
         3'd1: rd = {8'b0, hexdat};
         3'd2: rd = {26'b0, blank};
         3'd3: rd = {22'b0, deb[9:0]};
         3'd4: rd = {29'b0, ~deb[12:10]};
         3'd5: rd = {29'b0, keyev};
         3'd6: rd = cycles;
         default: rd = '0;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ledr            <= '0;
         hexdat          <= '0;
         blank           <= 6'h3F;
         keyev           <= '0;
         cycles          <= '0;
         s1              <= IN_RST;
         s2              <= IN_RST;
         deb             <= IN_RST;
         cnt             <= '0;
         hex_r           <= {6{7'h7F}};
         bus.io_readdata <= '0;
      end else begin
         s1              <= {key_in, sw_in};
         s2              <= s1;
         deb             <= deb_nxt;
         cnt             <= cnt_nxt;
         keyev           <= (keyev & ~clr) | press;
         cycles          <= cycles + 32'd1;
         bus.io_readdata <= rd;
         ledr            <= (wr && off == 3'd0) ? bus.writedata[9:0] : ledr;
         hexdat          <= (wr && off == 3'd1) ? bus.writedata[23:0] : hexdat;
         blank           <= (wr && off == 3'd2) ? bus.writedata[5:0] : blank;
         for (int n = 0; n < 6; n++)
            hex_r[n] <= blank[n] ? 7'h7F : SEG[hexdat[4*n +: 4]];
      end
   end
endmodule
